div_iter: RTL and testbench

//  Iterative restoring divider for the EX stage that produces DIV/DIVU results for HI/LO.

---
 rtl/div_iter.sv | 177 +++++++++++++++++
 tb/tb_div_iter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, with
// result_o = {remainder, quotient} feeding the HI/LO write path.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               stallreq_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn1_q, sgn1_d;
  logic               sgn2_q, sgn2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     trial, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic               neg_quo, neg_rem;
  logic [WIDTH-1:0]   fix_rem, fix_quo, bz_rem;

  assign accept    = (state_q == S_IDLE) && start_i && !annul_i;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      signed_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      signed_q <= signed_d;
      result_q <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (opdata2_i == {WIDTH{1'b0}}) ? S_BYZERO : S_ON;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_END;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_END;
        end else begin
          state_d = S_ON;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, restoring step, and result formation with sign fix
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    signed_d = signed_q;
    result_d = result_q;

    mag1 = (signed_i && opdata1_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
    mag2 = (signed_i && opdata2_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;

    // quo_q doubles as the dividend shift register; a clear borrow bit means partial >= divisor
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    ge      = ~diff[WIDTH];
    rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};

    neg_quo = signed_q && (sgn1_q ^ sgn2_q);
    neg_rem = signed_q && sgn1_q;
    fix_rem = neg_rem ? ({WIDTH{1'b0}} - rem_nxt) : rem_nxt;
    fix_quo = neg_quo ? ({WIDTH{1'b0}} - quo_nxt) : quo_nxt;
    bz_rem  = neg_rem ? ({WIDTH{1'b0}} - quo_q) : quo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = mag1;
          dvs_d    = mag2;
          sgn1_d   = opdata1_i[WIDTH-1];
          sgn2_d   = opdata2_i[WIDTH-1];
          signed_d = signed_i;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ON: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CW'(1);
        if (!annul_i && last_iter) begin
          result_d = {fix_rem, fix_quo};
        end else begin
          result_d = result_q;
        end
      end
      S_BYZERO: begin
        if (!annul_i) begin
          result_d = {bz_rem, {WIDTH{1'b1}}};
        end else begin
          result_d = result_q;
        end
      end
      default: result_d = result_q;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o     = (state_q == S_ON) || (state_q == S_BYZERO);
    stallreq_o = accept || (state_q == S_ON) || (state_q == S_BYZERO);
    ready_o    = (state_q == S_END);
    result_o   = result_q;
  end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter (WIDTH=32): directed spec cases plus random operands
// checked against an integer-arithmetic reference.
module tb_div_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic [W-1:0] opdata1_i = '0;
  logic [W-1:0] opdata2_i = '0;
  logic         annul_i = 1'b0;
  logic         busy_o, stallreq_o, ready_o;
  logic [2*W-1:0] result_o;

  int total = 0;
  int bad = 0;
  logic [63:0] last_res = 64'd0;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy_o), .stallreq_o(stallreq_o), .ready_o(ready_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (truncating), zero divisor gives all-ones / dividend
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Starts in the cycle after the previous call's END (back-to-back); annul_at < 0 means no abort
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int annul_at, input logic annul_in_end);
    int cyc;
    int exp_lat;
    logic aborted;
    exp_lat = (b == 32'd0) ? 2 : W + 1;
    aborted = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("idle_ready", {63'd0, ready_o}, 64'd0);
    check("result_hold", result_o, last_res);
    start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
    #1;
    check("stall_cycle0", {63'd0, stallreq_o}, 64'd1);
    @(posedge clk); #1;
    cyc = 1;
    while (1) begin
      if (ready_o) break;
      if (cyc > W + 2) begin
        check("ready_timeout", {63'd0, ready_o}, 64'd1);
        break;
      end
      check("busy_run", {63'd0, busy_o}, 64'd1);
      check("stall_run", {63'd0, stallreq_o}, 64'd1);
      // Input junk while busy must not disturb the operation
      start_i = 1'($urandom_range(0, 1));
      opdata1_i = $urandom; opdata2_i = $urandom; signed_i = 1'($urandom_range(0, 1));
      if (cyc == annul_at) begin
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        check("annul_busy", {63'd0, busy_o}, 64'd0);
        check("annul_stall", {63'd0, stallreq_o}, 64'd0);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        check("annul_result", result_o, last_res);
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    if (!aborted && ready_o) begin
      if (annul_in_end) annul_i = 1'b1;
      check("latency", 64'(cyc), 64'(exp_lat));
      check("stall_end", {63'd0, stallreq_o}, 64'd0);
      check("busy_end", {63'd0, busy_o}, 64'd0);
      check("result", result_o, exp);
      last_res = exp;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_stall", {63'd0, stallreq_o}, 64'd0);

    // T1..T4 back-to-back, T2 with annul held during END
    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, -1, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1, 1'b1);
    run_div(32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, -1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, -1, 1'b0);
    run_div(32'hFFFF_FF00, 32'd0, 1'b1, {32'hFFFF_FF00, 32'hFFFF_FFFF}, -1, 1'b0);
    run_div(32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, -1, 1'b0);

    // T5: abort in cycle 10; the following run starts in cycle 12
    run_div(32'd1000, 32'd3, 1'b0, 64'd0, 10, 1'b0);
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, -1, 1'b0);
    // Abort while dividing by zero
    run_div(32'd77, 32'd0, 1'b0, 64'd0, 1, 1'b0);

    // start together with annul in IDLE is not accepted
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    #1;
    check("annul_idle_stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    check("annul_idle_busy", {63'd0, busy_o}, 64'd0);

    // Random operands, with some zero and extreme divisors mixed in
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case (i % 6)
        0: rb = 32'd0;
        1: rb = rb >> $urandom_range(0, 31);
        2: ra = ra >> $urandom_range(0, 31);
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_div(ra, rb, rs, model(ra, rb, rs), -1, 1'b0);
    end

    // T6: reset in cycle 5 of an operation
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd11;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_ready", {63'd0, ready_o}, 64'd0);
    check("t6_busy", {63'd0, busy_o}, 64'd0);
    check("t6_stall", {63'd0, stallreq_o}, 64'd0);
    check("t6_result", result_o, 64'd0);
    last_res = 64'd0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      check("t6_no_ready", {63'd0, ready_o}, 64'd0);
    end
    run_div(32'd200, 32'd7, 1'b0, {32'd4, 32'd28}, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
